// File: rtl/arith_pkg.sv
// arith_pkg: state encoding and borrow helper shared by the serial subtractor datapath
package arith_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic logic borrow_f(input logic a, input logic b, input logic bin);
    return (~a & b) | (~a & bin) | (b & bin);
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit a - b - bin cell with borrow out
module full_subtractor
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = borrow_f(a, b, bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with held result, borrow and signed overflow
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_d_q, sh_d_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, sa_q, sa_d, sb_q, sb_d;
  logic             done_q, done_d, bo_q, bo_d, ov_q, ov_d;
  logic             fs_d, fs_b, last;
  full_subtractor u_fs (
    .a   (sh_a_q[0]),
    .b   (sh_b_q[0]),
    .bin (br_q),
    .d   (fs_d),
    .bout(fs_b)
  );
  assign last       = (cnt_q == CW'(WIDTH - 1));
  assign ready      = (state_q == IDLE);
  assign busy       = ~ready;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;
  // next state: capture on accept, one subtractor bit per RUN cycle, publish result on the last bit
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_d_d  = sh_d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        sh_a_d  = a;
        sh_b_d  = b;
        sh_d_d  = '0;
        cnt_d   = '0;
        br_d    = 1'b0;
        sa_d    = a[WIDTH-1];
        sb_d    = b[WIDTH-1];
      end
      RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        sh_d_d  = {fs_d, sh_d_q[WIDTH-1:1]};
        br_d    = fs_b;
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? DONE : RUN;
        done_d  = last;
        diff_d  = last ? {fs_d, sh_d_q[WIDTH-1:1]} : diff_q;
        bo_d    = last ? fs_b : bo_q;
        ov_d    = last ? ((sa_q != sb_q) && (fs_d != sa_q)) : ov_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any operation without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_d_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_d_q  <= sh_d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: cycle model plus directed literal checks for the bit-serial subtractor
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic ready, busy, done, borrow_out, overflow;
  logic [W-1:0] diff;
  int vec = 0, errs = 0, done_cnt = 0;
  int m_rem = 0;
  logic m_done = 1'b0, m_bo = 1'b0, m_ov = 1'b0, p_bo = 1'b0, p_ov = 1'b0;
  logic [W-1:0] m_diff = '0, p_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int s;
    s = int'($signed(x)) - int'($signed(y));
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: an accepted op keeps the block busy for W+1 cycles and publishes its result W edges later
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_rem  <= 0;
      m_diff <= '0;
      m_bo   <= 1'b0;
      m_ov   <= 1'b0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_rem  <= W + 1;
        p_diff <= a - b;
        p_bo   <= a < b;
        p_ov   <= sovf(a, b);
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_done <= 1'b1;
        m_diff <= p_diff;
        m_bo   <= p_bo;
        m_ov   <= p_ov;
      end
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    chk("ready", W'(ready), W'(m_rem == 0));
    chk("busy", W'(busy), W'(m_rem != 0));
    chk("done", W'(done), W'(m_done));
    chk("diff", diff, m_diff);
    chk("borrow_out", W'(borrow_out), W'(m_bo));
    chk("overflow", W'(overflow), W'(m_ov));
  end

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    a = x;
    b = y;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(0, n);
    chk("latency", W'(n), W'(W));
    chk("lit_diff", diff, ed);
    chk("lit_borrow", W'(borrow_out), W'(eb));
    chk("lit_ovf", W'(overflow), W'(eo));
    tick;
  endtask

  initial begin
    int n, d0;
    tick;
    tick;
    chk("rst_diff", diff, '0);
    chk("rst_ready", W'(ready), W'(1));
    rst = 1'b0;
    tick;
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    // start and operand changes mid-run are ignored
    d0 = done_cnt;
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    a = 8'hAA;
    b = 8'h11;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(4, n);
    chk("ign_latency", W'(n), W'(W));
    chk("ign_diff", diff, 8'h02);
    repeat (4) tick;
    chk("ign_done_count", W'(done_cnt - d0), W'(1));
    // reset mid-run aborts without a done pulse
    d0 = done_cnt;
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_ready", W'(ready), W'(1));
    chk("abort_diff", diff, '0);
    chk("abort_done", W'(done), W'(0));
    repeat (12) tick;
    chk("abort_no_done", W'(done_cnt - d0), W'(0));
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    // back-to-back with start held high and operands changing every cycle
    d0 = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 1000 * (W + 2); i++) begin
      a = W'($urandom);
      b = W'($urandom);
      tick;
    end
    start = 1'b0;
    chk("b2b_done_count", W'((done_cnt - d0) % 256), W'(1000 % 256));
    vec++;
    if (done_cnt - d0 != 1000) begin
      errs++;
      $display("FAIL b2b_done_total: got %0d expected 1000", done_cnt - d0);
    end
    repeat (W + 4) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
